// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_rx_pkg;

  localparam int unsigned UART_DATA_WIDTH_DEFAULT = 8;

  localparam int unsigned LSB_FIRST = 0;
  localparam int unsigned MSB_FIRST = 1;

  localparam int unsigned EVEN = 0;
  localparam int unsigned ODD  = 1;

  // Width needed to hold a bit count from 0 up to and including data_width.
  function automatic int unsigned cnt_width(input int unsigned data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/uart_rx_out_reg.sv
// Output holding register: captures a committed word with its parity and offers it
// on a valid/ready handshake, flagging words that overwrite unconsumed data.
module uart_rx_out_reg #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  out_ready,
  input  logic                  overrun_clr,
  output logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  expected_parity,
  output logic                  data_valid,
  output logic                  overrun
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  parity_q, parity_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  overrun_set;

  always_comb begin
    data_d      = data_q;
    parity_d    = parity_q;
    valid_d     = valid_q;
    overrun_set = commit && valid_q && !out_ready;
    if (commit) begin
      data_d   = word;
      parity_d = (^word) ^ 1'(ODD_PARITY);
      valid_d  = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    // A new overrun in the same cycle as a clear keeps the flag set.
    overrun_d = overrun_set || (overrun_q && !overrun_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      parity_q  <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      parity_q  <= parity_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign parallel_data   = data_q;
  assign expected_parity = parity_q;
  assign data_valid      = valid_q;
  assign overrun         = overrun_q;

endmodule

// File: rtl/uart_deserializer_param.sv
// Parametrised UART-RX deserializer: shifts sampled bits into a word, tracks the frame
// fill level and commits completed words into the holding register.
module uart_deserializer_param #(
  parameter int unsigned DATA_WIDTH = uart_rx_pkg::UART_DATA_WIDTH_DEFAULT,
  parameter int unsigned MSB_FIRST  = uart_rx_pkg::LSB_FIRST,
  parameter int unsigned ODD_PARITY = uart_rx_pkg::EVEN
) (
  input  logic                                          clk_based_on_prescale,
  input  logic                                          asy_reset,
  input  logic                                          sampled_data,
  input  logic                                          sampled_data_valid,
  input  logic                                          Deserializer_enable,
  input  logic                                          frame_abort,
  input  logic                                          out_ready,
  input  logic                                          overrun_clr,
  output logic [DATA_WIDTH-1:0]                         parallel_data,
  output logic                                          expected_parity,
  output logic                                          data_valid,
  output logic [uart_rx_pkg::cnt_width(DATA_WIDTH)-1:0] bit_count,
  output logic                                          frame_full,
  output logic                                          short_frame,
  output logic                                          overrun
);

  import uart_rx_pkg::*;

  localparam int unsigned     CntW      = cnt_width(DATA_WIDTH);
  localparam logic [CntW-1:0] FullCount = CntW'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  short_q, short_d;
  logic                  full;
  logic                  commit;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    if (MSB_FIRST != 0) return {w[DATA_WIDTH-2:0], b};
    return {b, w[DATA_WIDTH-1:1]};
  endfunction

  assign full = (count_q == FullCount);

  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    short_d = 1'b0;
    commit  = 1'b0;
    if (frame_abort) begin
      shreg_d = '0;
      count_d = '0;
    end else if (Deserializer_enable) begin
      commit  = full;
      short_d = !full;
      // A bit arriving with the commit opens the next frame.
      if (sampled_data_valid) begin
        shreg_d = shift_in('0, sampled_data);
        count_d = CntW'(1);
      end else begin
        shreg_d = '0;
        count_d = '0;
      end
    end else if (sampled_data_valid && !full) begin
      shreg_d = shift_in(shreg_q, sampled_data);
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_based_on_prescale) begin
    if (asy_reset) begin
      shreg_q <= '0;
      count_q <= '0;
      short_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
      short_q <= short_d;
    end
  end

  uart_rx_out_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .ODD_PARITY(ODD_PARITY)
  ) u_out_reg (
    .clk            (clk_based_on_prescale),
    .rst            (asy_reset),
    .commit         (commit),
    .word           (shreg_q),
    .out_ready      (out_ready),
    .overrun_clr    (overrun_clr),
    .parallel_data  (parallel_data),
    .expected_parity(expected_parity),
    .data_valid     (data_valid),
    .overrun        (overrun)
  );

  assign bit_count   = count_q;
  assign frame_full  = full;
  assign short_frame = short_q;

endmodule
